// File: rtl/decode_stage.sv
// Decode stage: IF/ID fields -> registered ID/EX bundle. Holds the 8x16 register
// file, load-use interlock and the two-word LDM assembler.
module decode_stage #(
  parameter int unsigned REG_W = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [5:0]       opcode,
  input  logic [2:0]       src,
  input  logic [2:0]       dst,
  input  logic [3:0]       shiftamount,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [2:0]       wb_addr,
  input  logic [REG_W-1:0] wb_data,
  output logic             stall_fetch,
  output logic             ex_valid,
  output logic [5:0]       ex_opcode,
  output logic [2:0]       ex_src,
  output logic [2:0]       ex_dst,
  output logic [3:0]       ex_shamt,
  output logic [REG_W-1:0] ex_rsrc,
  output logic [REG_W-1:0] ex_rdst,
  output logic [REG_W-1:0] ex_imm,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_illegal
);

  localparam logic [5:0] OP_NOP = 6'b000101;
  localparam logic [5:0] OP_ADD = 6'b000011;
  localparam logic [5:0] OP_NOT = 6'b000100;
  localparam logic [5:0] OP_SHL = 6'b000110;
  localparam logic [5:0] OP_LDD = 6'b010001;
  localparam logic [5:0] OP_STD = 6'b010010;
  localparam logic [5:0] OP_LDM = 6'b010011;

  typedef enum logic {NORMAL, WAIT_IMM} state_t;

  state_t           state, state_nxt;
  logic [2:0]       ldm_dst;
  logic [REG_W-1:0] regs [NREGS];
  logic [REG_W-1:0] rsrc_val, rdst_val;
  logic             accept;

  logic             n_valid, n_reg_write, n_mem_read, n_mem_write, n_illegal;
  logic [5:0]       n_opcode;
  logic [2:0]       n_src, n_dst;
  logic [3:0]       n_shamt;
  logic [REG_W-1:0] n_rsrc, n_rdst, n_imm;

  // Register file; writes proceed regardless of stall or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rsrc_val = (wb_en && wb_addr == src) ? wb_data : regs[src];
    rdst_val = (wb_en && wb_addr == dst) ? wb_data : regs[dst];
  end

  always_comb begin
    stall_fetch = if_valid && !flush && state == NORMAL && ex_valid && ex_mem_read &&
                  opcode != OP_NOP && opcode != OP_LDM &&
                  (ex_dst == src || ex_dst == dst);
    accept      = if_valid && !stall_fetch && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= NORMAL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = NORMAL;
    end else if (accept) begin
      case (state)
        NORMAL:   if (opcode == OP_LDM) state_nxt = WAIT_IMM;
        WAIT_IMM: state_nxt = NORMAL;
        default:  state_nxt = NORMAL;
      endcase
    end
  end

  // Next ID/EX bundle; anything not accepted becomes an all-zero bubble
  always_comb begin
    n_valid     = 1'b0;
    n_opcode    = '0;
    n_src       = '0;
    n_dst       = '0;
    n_shamt     = '0;
    n_rsrc      = '0;
    n_rdst      = '0;
    n_imm       = '0;
    n_reg_write = 1'b0;
    n_mem_read  = 1'b0;
    n_mem_write = 1'b0;
    n_illegal   = 1'b0;
    if (accept) begin
      case (state)
        WAIT_IMM: begin
          n_valid     = 1'b1;
          n_opcode    = OP_LDM;
          n_dst       = ldm_dst;
          n_imm       = REG_W'({opcode, src, dst, shiftamount});
          n_reg_write = 1'b1;
        end
        default: begin
          if (opcode != OP_LDM) begin
            n_valid  = 1'b1;
            n_opcode = opcode;
            n_src    = src;
            n_dst    = dst;
            n_shamt  = shiftamount;
            n_rsrc   = rsrc_val;
            n_rdst   = rdst_val;
            case (opcode)
              OP_NOP:                 ;
              OP_ADD, OP_NOT, OP_SHL: n_reg_write = 1'b1;
              OP_LDD: begin
                n_mem_read  = 1'b1;
                n_reg_write = 1'b1;
              end
              OP_STD:                 n_mem_write = 1'b1;
              default:                n_illegal   = 1'b1;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ldm_dst <= '0;
    end else if (accept && state == NORMAL && opcode == OP_LDM) begin
      ldm_dst <= dst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_src       <= '0;
      ex_dst       <= '0;
      ex_shamt     <= '0;
      ex_rsrc      <= '0;
      ex_rdst      <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_illegal   <= 1'b0;
    end else begin
      ex_valid     <= n_valid;
      ex_opcode    <= n_opcode;
      ex_src       <= n_src;
      ex_dst       <= n_dst;
      ex_shamt     <= n_shamt;
      ex_rsrc      <= n_rsrc;
      ex_rdst      <= n_rdst;
      ex_imm       <= n_imm;
      ex_reg_write <= n_reg_write;
      ex_mem_read  <= n_mem_read;
      ex_mem_write <= n_mem_write;
      ex_illegal   <= n_illegal;
    end
  end

endmodule
